req_encoder8to3: RTL
====================

REQ_ENCODER8TO3 -- requirements
Module: req_encoder8to3

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 en  input  1  capture enable; when low, in is ignored.
REQ-004 in  input  8  one-hot or multi-hot request lines, bit i = request i.
REQ-005 ack  input  1  consumer accepts the presented code; meaningful only while valid=1.
REQ-006 out  output  3  registered binary index of the granted request.
REQ-007 valid  output  1  registered; out holds a granted index awaiting ack.
REQ-008 pending  output  8  registered sticky request register, bit i = request i outstanding.

Function
REQ-009 pending update per cycle: pending_next = (pending & ~clr) | (en ? in : 8'h00); clr = one-hot of out when valid&ack, else 0.
REQ-010 Simultaneous set and clear of the same bit: set wins; the bit stays 1 and is re-served later.
REQ-011 FSM states IDLE and PRESENT; reset state IDLE.
REQ-012 IDLE: if pending != 0, load out with selected index, set valid=1, go to PRESENT; else hold out, valid=0.
REQ-013 PRESENT: out and valid held stable until ack=1; on ack, valid=0 next cycle, return to IDLE.
REQ-014 Selection uses registered pending, not in; requests arriving in the same cycle as a grant decision are not considered until the next IDLE cycle.
REQ-015 Latency: in[i] with en=1 at edge N -> pending[i]=1 after edge N -> valid=1, out=i after edge N+1 (if i is selected).
REQ-016 Throughput: at most one grant per two cycles (PRESENT + IDLE).
REQ-017 ack while valid=0 has no effect on any state.
REQ-018 en=0 does not stall service; existing pending bits continue to be granted.
REQ-019 Default selection: fixed priority, highest index wins (bit 7 highest, bit 0 lowest).
REQ-020 A pending bit is cleared only by ack of its grant or by rst; no other clear path.
REQ-021 out is never X; in IDLE with pending=0 it retains its last value (3'b000 after reset).

Reset
REQ-022 rst=1 at an edge: pending=8'h00, out=3'b000, valid=0, FSM=IDLE, round-robin pointer (if compiled) = 3'b111.
REQ-023 rst takes precedence over en, in and ack in the same cycle; in is not captured.
REQ-024 rst mid-grant (PRESENT) abandons the grant; the request is lost and not re-presented.

Configuration
REQ-025 Macro REQ_ENCODER_RR_EN selects the arbitration policy.
REQ-026 Without REQ_ENCODER_RR_EN: fixed priority per REQ-019; no pointer register exists.
REQ-027 With REQ_ENCODER_RR_EN: 3-bit pointer last holds the index of the last acked grant; the search starts at last+1 and ascends modulo 8 (7 wraps to 0); the first set pending bit wins.
REQ-028 With REQ_ENCODER_RR_EN: last updates only on valid&ack; it does not update on grant without ack.
REQ-029 Interface, latency and handshake are identical in both builds.

Verification
REQ-030 rst=1 for 2 cycles with in=8'hFF, en=1 -> pending=8'h00, valid=0, out=3'b000.
REQ-031 en=1, in=8'b0010_0000 for one cycle, ack tied 1 -> valid=1, out=3'd5 two edges later; pending=8'h00 one cycle after ack.
REQ-032 Fixed priority: one-cycle in=8'b1000_0101, ack=1 continuously -> grants in order 7, 2, 0, one every two cycles; then valid=0.
REQ-033 Set wins: pending[3] granted and ack asserted in the same cycle that in[3]=1, en=1 -> pending[3] remains 1 and 3 is granted again.
REQ-034 en=0, in=8'hFF -> pending is unchanged; ack pulsed while valid=0 -> no state change.
REQ-035 REQ_ENCODER_RR_EN build: in=8'hFF held with en=1, ack=1 -> grants 0,1,2,...,7,0 (wrap after reset pointer 7); fixed build with the same stimulus -> grants 7,7,7.

Source files
------------

// File: rtl/req_encoder8to3.sv
// req_encoder8to3: sticky request register feeding a one-at-a-time grant encoder.
//
// Requests on in (when en=1) are accumulated into pending. While idle, the
// encoder picks one pending index from the registered pending vector, presents
// it on out with valid=1, and holds it until ack. An acked index is cleared
// from pending, unless the same request is set again in that cycle, in which
// case the set wins.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-high reset
//   en       in   1  capture enable for in
//   in       in   8  request lines, bit i = request i
//   ack      in   1  consumer accepts out (only meaningful while valid=1)
//   out      out  3  registered granted index
//   valid    out  1  registered, out holds a grant awaiting ack
//   pending  out  8  registered sticky request vector
//
// Build option: define REQ_ENCODER_RR_EN for round-robin arbitration starting
// after the last acked index; the default build uses fixed priority, with
// bit 7 highest.

module req_encoder8to3 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] in,
  input  logic       ack,
  output logic [2:0] out,
  output logic       valid,
  output logic [7:0] pending
);

  typedef enum logic [0:0] {StIdle, StPresent} state_e;

  state_e     state_q, state_d;
  logic [7:0] pending_d;
  logic [7:0] clr;
  logic [2:0] out_d;
  logic       valid_d;
  logic [2:0] sel;

`ifdef REQ_ENCODER_RR_EN
  logic [2:0] last_q, last_d;

  // Search upward from last+1, wrapping modulo 8; the first set bit wins.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    sel   = 3'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      idx = last_q + 3'(k + 1);
      if (!found && pending[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // The pointer moves only on an accepted grant.
  always_comb begin
    last_d = last_q;
    if (valid && ack) begin
      last_d = out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 3'b111;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: the loop order lets the highest set index win.
  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) begin
        sel = 3'(i);
      end
    end
  end
`endif

  // Clear only the bit whose grant is being accepted; a new set in the same
  // cycle overrides the clear.
  always_comb begin
    clr = 8'h00;
    if (valid && ack) begin
      clr[out] = 1'b1;
    end
    pending_d = (pending & ~clr) | (en ? in : 8'h00);
  end

  always_comb begin
    state_d = state_q;
    out_d   = out;
    valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (|pending) begin
          out_d   = sel;
          valid_d = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (ack) begin
          state_d = StIdle;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pending <= 8'h00;
      out     <= 3'b000;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      pending <= pending_d;
      out     <= out_d;
      valid   <= valid_d;
    end
  end

endmodule
